// File: rtl/shake_client_arbiter.sv
// Round-robin arbiter sharing one SHAKE core between several word-streaming clients.
// A grant holds one client on both the load and result paths until the core reports done.
module shake_client_arbiter #(
    parameter int N_CLIENTS = 2,
    parameter int W         = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CLIENTS-1:0]   req_valid_in,
    input  logic [N_CLIENTS*W-1:0] req_data_in,
    output logic [N_CLIENTS-1:0]   req_ready_out,
    output logic                   core_valid_out,
    output logic [W-1:0]           core_data_out,
    input  logic                   core_ready_in,
    input  logic                   core_result_valid_in,
    input  logic [W-1:0]           core_result_data_in,
    output logic                   core_result_ready_out,
    input  logic                   core_done_in,
    output logic [N_CLIENTS-1:0]   resp_valid_out,
    output logic [W-1:0]           resp_data_out,
    input  logic [N_CLIENTS-1:0]   resp_ready_in,
    output logic [N_CLIENTS-1:0]   grant_out,
    output logic                   busy_out
);

    localparam int IW = $clog2(N_CLIENTS);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [N_CLIENTS-1:0] r_grant;
    logic [N_CLIENTS-1:0] w_grant_next;
    logic [IW-1:0]        r_last_grant;
    logic [IW-1:0]        w_last_grant_next;

    logic [IW-1:0]        w_cand;
    logic [IW-1:0]        w_pick_idx;
    logic                 w_pick_found;
    logic [IW-1:0]        w_gidx;
    logic                 w_granted;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_last_grant <= IW'(N_CLIENTS - 1);
        end else begin
            r_state      <= w_state_next;
            r_grant      <= w_grant_next;
            r_last_grant <= w_last_grant_next;
        end
    end

    // Search upward from the client after the last one served, wrapping at N_CLIENTS.
    always_comb begin
        w_cand       = r_last_grant;
        w_pick_idx   = r_last_grant;
        w_pick_found = 1'b0;
        for (int k = 0; k < N_CLIENTS; k++) begin
            w_cand = (w_cand == IW'(N_CLIENTS - 1)) ? '0 : w_cand + 1'b1;
            if (!w_pick_found && req_valid_in[w_cand]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = w_cand;
            end
        end
    end

    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (r_grant[i]) begin
                w_gidx = IW'(i);
            end
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_grant_next      = r_grant;
        w_last_grant_next = r_last_grant;
        case (r_state)
            IDLE: begin
                if (w_pick_found) begin
                    w_state_next = GRANTED;
                    w_grant_next = '0;
                    w_grant_next[w_pick_idx] = 1'b1;
                end
            end
            GRANTED: begin
                // Only done releases the grant; the owner's valid dropping just stalls the core.
                if (core_done_in) begin
                    w_state_next      = IDLE;
                    w_grant_next      = '0;
                    w_last_grant_next = w_gidx;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_grant_next = '0;
            end
        endcase
    end

    assign w_granted = (r_state == GRANTED);

    always_comb begin
        core_valid_out        = 1'b0;
        core_data_out         = '0;
        core_result_ready_out = 1'b0;
        resp_data_out         = '0;
        if (w_granted) begin
            core_valid_out        = req_valid_in[w_gidx];
            core_data_out         = req_data_in[w_gidx*W +: W];
            core_result_ready_out = resp_ready_in[w_gidx];
            resp_data_out         = core_result_data_in;
        end
    end

    generate
        for (genvar gi = 0; gi < N_CLIENTS; gi++) begin : g_client
            assign req_ready_out[gi]  = w_granted & r_grant[gi] & core_ready_in;
            assign resp_valid_out[gi] = w_granted & r_grant[gi] & core_result_valid_in;
        end
    endgenerate

    assign grant_out = r_grant;
    assign busy_out  = w_granted;

endmodule

// File: tb/tb_shake_client_arbiter.sv
// Directed bench for shake_client_arbiter (two clients) with scoreboards on the load
// and result paths; expected words are queued when driven and popped on handshake.
module tb_shake_client_arbiter;

    localparam int N = 2;
    localparam int W = 64;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid_in;
    logic [N*W-1:0] req_data_in;
    logic [N-1:0]   req_ready_out;
    logic           core_valid_out;
    logic [W-1:0]   core_data_out;
    logic           core_ready_in;
    logic           core_result_valid_in;
    logic [W-1:0]   core_result_data_in;
    logic           core_result_ready_out;
    logic           core_done_in;
    logic [N-1:0]   resp_valid_out;
    logic [W-1:0]   resp_data_out;
    logic [N-1:0]   resp_ready_in;
    logic [N-1:0]   grant_out;
    logic           busy_out;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_core[$];
    logic [W-1:0] exp_resp[$];
    logic         rdy_tog;
    int           waited;

    shake_client_arbiter #(.N_CLIENTS(N), .W(W)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .req_valid_in          (req_valid_in),
        .req_data_in           (req_data_in),
        .req_ready_out         (req_ready_out),
        .core_valid_out        (core_valid_out),
        .core_data_out         (core_data_out),
        .core_ready_in         (core_ready_in),
        .core_result_valid_in  (core_result_valid_in),
        .core_result_data_in   (core_result_data_in),
        .core_result_ready_out (core_result_ready_out),
        .core_done_in          (core_done_in),
        .resp_valid_out        (resp_valid_out),
        .resp_data_out         (resp_data_out),
        .resp_ready_in         (resp_ready_in),
        .grant_out             (grant_out),
        .busy_out              (busy_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load-path scoreboard: each handshake must carry the next queued word.
    always @(negedge clk) begin
        if (rst && core_valid_out && core_ready_in) begin
            if (exp_core.size() == 0) begin
                chk("core_unexpected_word", core_data_out, '0);
            end else begin
                chk("core_word", core_data_out, exp_core.pop_front());
            end
        end
        if (rst && ((resp_valid_out & resp_ready_in) != '0)) begin
            if (exp_resp.size() == 0) begin
                chk("resp_unexpected_word", resp_data_out, '0);
            end else begin
                chk("resp_word", resp_data_out, exp_resp.pop_front());
            end
        end
    end

    // One full transaction for client c: n load words, optional nres result words, done.
    task automatic txn(input int c, input int n, input logic [W-1:0] base,
                       input int nres, output int wcount);
        logic [N-1:0] oh;
        logic         got;
        logic         sent;
        int           tries;
        oh = '0;
        oh[c] = 1'b1;
        got = 1'b0;
        wcount = 0;
        req_valid_in[c] = 1'b1;
        req_data_in[c*W +: W] = base;
        exp_core.push_back(base);
        while (!got && wcount < 8) begin
            tick();
            wcount++;
            #1;
            if (grant_out == oh) got = 1'b1;
        end
        chk("grant", grant_out, oh);
        chk("busy_granted", busy_out, 1);
        chk("req_ready_owner_only", req_ready_out, oh);
        chk("core_data_first", core_data_out, base);
        for (int i = 1; i < n; i++) begin
            tick();
            req_data_in[c*W +: W] = base + i;
            exp_core.push_back(base + i);
        end
        tick();
        req_valid_in[c] = 1'b0;
        for (int r = 0; r < nres; r++) begin
            core_result_valid_in = 1'b1;
            core_result_data_in  = 64'hC0 + r;
            exp_resp.push_back(64'hC0 + r);
            sent = 1'b0;
            tries = 0;
            while (!sent && tries < 8) begin
                rdy_tog = ~rdy_tog;
                resp_ready_in[c]     = rdy_tog;
                resp_ready_in[1 - c] = 1'b1;
                #1;
                chk("resp_valid_owner_only", resp_valid_out, oh);
                chk("result_ready_follows_owner", core_result_ready_out, resp_ready_in[c]);
                if (resp_ready_in[c]) sent = 1'b1;
                tick();
                tries++;
            end
            chk("result_sent", sent, 1);
        end
        core_result_valid_in = 1'b0;
        resp_ready_in = '0;
        core_done_in = 1'b1;
        #1;
        chk("busy_on_done_cycle", busy_out, 1);
        tick();
        core_done_in = 1'b0;
        #1;
        chk("busy_after_done", busy_out, 0);
        chk("grant_after_done", grant_out, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        req_valid_in = '0;
        req_data_in = '0;
        core_ready_in = 1'b0;
        core_result_valid_in = 1'b0;
        core_result_data_in = '0;
        core_done_in = 1'b0;
        resp_ready_in = '0;
        rdy_tog = 1'b0;
        repeat (2) tick();
        #1;
        chk("rst_grant", grant_out, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_core_valid", core_valid_out, 0);
        chk("rst_req_ready", req_ready_out, 0);
        tick();
        rst = 1'b1;

        // Single client 1, five words, then done; foreign data on client 0.
        core_ready_in = 1'b1;
        req_data_in[0 +: W] = 64'hDEAD;
        txn(1, 5, 64'h11, 0, waited);
        chk("t1_grant_latency", waited, 1);
        chk("t1_words_consumed", exp_core.size(), 0);

        // Contention from reset: 0 first, then 1 after one idle cycle, then 0 again.
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        req_valid_in = 2'b11;
        txn(0, 2, 64'hA0, 0, waited);
        chk("t2_first_latency", waited, 1);
        req_valid_in[0] = 1'b1;
        req_data_in[0 +: W] = 64'hA8;
        #1;
        chk("t2_idle_no_grant", grant_out, 0);
        txn(1, 2, 64'hB0, 0, waited);
        chk("t2_idle_gap", waited, 1);
        txn(0, 1, 64'hA8, 0, waited);
        chk("t2_third_gap", waited, 1);

        // Result routing for client 1 with toggling response ready.
        txn(1, 2, 64'h70, 4, waited);
        chk("t3_results_consumed", exp_resp.size(), 0);

        // Spurious done and result valid while idle.
        core_done_in = 1'b1;
        core_result_valid_in = 1'b1;
        core_result_data_in = 64'h77;
        #1;
        chk("sp_result_ready", core_result_ready_out, 0);
        chk("sp_resp_valid", resp_valid_out, 0);
        chk("sp_resp_data", resp_data_out, 0);
        chk("sp_core_data", core_data_out, 0);
        tick();
        core_done_in = 1'b0;
        core_result_valid_in = 1'b0;
        #1;
        chk("sp_grant", grant_out, 0);
        chk("sp_busy", busy_out, 0);

        // Stall: client 0 owns the core, drops valid for 3 cycles while client 1 waits.
        req_valid_in = 2'b11;
        req_data_in[0 +: W] = 64'h50;
        req_data_in[W +: W] = 64'h99;
        exp_core.push_back(64'h50);
        tick();
        #1;
        chk("st_grant", grant_out, 2'b01);
        tick();
        req_valid_in[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("st_grant_hold", grant_out, 2'b01);
            chk("st_core_valid_gap", core_valid_out, 0);
            chk("st_req_ready", req_ready_out, 2'b01);
            tick();
        end
        req_valid_in[0] = 1'b1;
        req_data_in[0 +: W] = 64'h51;
        exp_core.push_back(64'h51);
        tick();
        req_valid_in = 2'b00;
        core_done_in = 1'b1;
        tick();
        core_done_in = 1'b0;
        #1;
        chk("st_busy_after", busy_out, 0);
        chk("st_words_consumed", exp_core.size(), 0);

        // Reset in the middle of client 1's message.
        req_valid_in[1] = 1'b1;
        req_data_in[W +: W] = 64'h61;
        exp_core.push_back(64'h61);
        tick();
        #1;
        chk("rm_grant", grant_out, 2'b10);
        tick();
        req_data_in[W +: W] = 64'h62;
        #1;
        rst = 1'b0;
        #1;
        chk("rm_grant_zero", grant_out, 0);
        chk("rm_busy_zero", busy_out, 0);
        chk("rm_core_valid_zero", core_valid_out, 0);
        chk("rm_req_ready_zero", req_ready_out, 0);
        chk("rm_core_data_zero", core_data_out, 0);
        core_ready_in = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        req_valid_in = 2'b11;
        tick();
        #1;
        chk("rm_client0_wins", grant_out, 2'b01);
        chk("rm_words_consumed", exp_core.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shake_client_arbiter.md
# shake_client_arbiter

Round-robin arbiter that shares one SHAKE core between `N_CLIENTS` word-streaming requesters. It sits in front of the core's load stage, which it drives through `valid_in`/`data_in`/`ready_out`, and behind its output stage. A grant locks one client onto both the input and result paths for a whole transaction. The grant is released only when the core signals transaction completion, so request words from different clients never interleave inside the core.

## Interface
- `N_CLIENTS`, default 2: number of requesters; valid range 2..8.
- `W`, default `w` from `keccak_pkg` (64): word width of the request and result streams.

- `clk`, input, 1: single clock; all logic rising-edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `req_valid_in`, input, `N_CLIENTS`: per-client request word valid.
- `req_data_in`, input, `N_CLIENTS*W`: per-client request word; client i occupies bits `[i*W +: W]`.
- `req_ready_out`, output, `N_CLIENTS`: per-client request word accepted.
- `core_valid_out`, output, 1: to core load stage `valid_in`.
- `core_data_out`, output, `W`: to core load stage `data_in`.
- `core_ready_in`, input, 1: from core load stage `ready_out`.
- `core_result_valid_in`, input, 1: core result word valid.
- `core_result_data_in`, input, `W`: core result word.
- `core_result_ready_out`, output, 1: result word accepted.
- `core_done_in`, input, 1: one-cycle pulse with the core's final result handshake.
- `resp_valid_out`, output, `N_CLIENTS`: per-client result valid.
- `resp_data_out`, output, `W`: result data, broadcast to all clients.
- `resp_ready_in`, input, `N_CLIENTS`: per-client result ready.
- `grant_out`, output, `N_CLIENTS`: one-hot current owner; all-zero when idle.
- `busy_out`, output, 1: high while a transaction is granted.

## Operation
- **FSM states:** `IDLE` and `GRANTED`.
- **`IDLE` behaviour:**
  - `grant_out`, `req_ready_out`, `core_valid_out`, `core_result_ready_out` and `resp_valid_out` are all 0.
  - If any `req_valid_in` bit is high, the arbiter selects the first requesting client searching upward (mod N) from `last_grant+1`.
  - It registers the one-hot grant and enters `GRANTED` on the next edge.
- **`GRANTED` forwarding (combinational, for granted client g):**
  - `core_valid_out = req_valid_in[g]`
  - `core_data_out = req_data_in[g]`
  - `req_ready_out[g] = core_ready_in`, other ready bits 0
  - `resp_valid_out[g] = core_result_valid_in`, other valid bits 0
  - `core_result_ready_out = resp_ready_in[g]`
- **Leaving `GRANTED`:** when `core_done_in` is sampled high in `GRANTED`, the FSM returns to `IDLE`, `last_grant <= g` and the grant is cleared.
- **Grant stability:**
  - The grant never changes while in `GRANTED`.
  - A granted client deasserting `req_valid_in` mid-message keeps the grant, stalling the core.
  - Other clients' valid bits have no effect.
- **Ignored inputs:** `core_done_in` in `IDLE` is ignored, as are `core_result_valid_in` words in `IDLE` (they are not accepted).
- **Bus contents when not forwarding:** `core_data_out` and `resp_data_out` are 0 in `IDLE`. `resp_data_out = core_result_data_in` in `GRANTED`.
- **Fairness:** the just-served client has the lowest priority at the next arbitration. With all clients requesting, grants rotate 0,1,..,N-1,0.

## Timing
- **Reset values:**
  - State `IDLE`.
  - `grant_out = 0`, `busy_out = 0`.
  - `last_grant = N_CLIENTS-1`, so client 0 wins first.
  - All handshake outputs 0.
- **Grant latency:** request seen high in `IDLE` at edge k gives `grant_out`/`busy_out` high after edge k; the first word can transfer in cycle k+1.
- **Datapath latency:** zero-cycle combinational forwarding in `GRANTED`; no buffering, no word loss or duplication.
- **Turnaround:** `core_done_in` at edge m gives `IDLE` in cycle m+1. The next grant is visible after edge m+1, so there is a minimum of one idle cycle between transactions.
- **Simultaneous `core_done_in` and a pending request:** done has priority; arbitration happens in the following `IDLE` cycle and uses the updated `last_grant`.
- **Reset mid-transaction:** the grant is dropped immediately (asynchronous) and all outputs go to their reset values. The core is reset by the same `rst`.
- **Handshake rules:**
  - A word transfers on any cycle with valid and ready both high.
  - Valid must not depend on ready, on either side.

## Test plan
- **Single client:** `N_CLIENTS=2`; client 1 sends 5 words `0x11..0x15` with `core_ready_in` constantly 1, then `core_done_in` is pulsed.
  - Required: `grant_out=2'b10` one cycle after `req_valid_in[1]`.
  - Required: `core_data_out` shows the 5 words in order, each once.
  - Required: `busy_out` falls the cycle after done.
- **Contention:** both clients request from reset.
  - Required: client 0 is granted first; after its done, client 1 is granted with exactly one `IDLE` cycle between.
  - Required: a third request from client 0 is granted after client 1.
- **Stalls:** granted client 0 drops valid for 3 cycles mid-message while client 1 requests.
  - Required: the grant stays `2'b01`.
  - Required: `core_valid_out` is 0 during the gap and `req_ready_out[1]` stays 0.
- **Result routing:** core returns 4 result words with `resp_ready_in` toggling.
  - Required: only `resp_valid_out[g]` is asserted.
  - Required: words transfer only on `resp_ready_in[g]=1` cycles, with no loss.
- **Spurious inputs:** `core_done_in` and `core_result_valid_in` are pulsed in `IDLE`.
  - Required: no state change, `core_result_ready_out=0`, no grant.
- **Reset mid-transaction:** `rst` is asserted low for 2 cycles during client 1's message, then both clients request.
  - Required: outputs are zeroed immediately on the reset assertion.
  - Required: client 0 wins the first arbitration after release.
